button_event_gen: RTL

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/button_event_gen.sv
// Press/release/auto-repeat event generator for four debounced buttons.
// Auto-repeat (shared prescaler plus per-button tick counters) is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_event_gen #(
  parameter int DIV_WIDTH    = 16,
  parameter int HOLD_TICKS   = 24,
  parameter int REPEAT_TICKS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button_in,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic [3:0] repeat_pulse,
  output logic [3:0] held,
  output logic       any_event
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t     state [4];
  logic [3:0] press_cond;
  logic [3:0] release_cond;
  logic [3:0] repeat_cond;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      press_cond[i]   = (state[i] == IDLE) && button_in[i];
      release_cond[i] = (state[i] != IDLE) && !button_in[i];
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  logic [DIV_WIDTH-1:0] prescaler;
  logic                 tick;
  logic [7:0]           count [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prescaler <= '0;
    else        prescaler <= prescaler + 1'b1;
  end

  // Ticks follow the free-running prescaler, so the first one after a press may come early.
  assign tick = &prescaler;

  always_comb begin
    for (int i = 0; i < 4; i++)
      repeat_cond[i] = (state[i] != IDLE) && button_in[i] && tick && (count[i] == 8'd1);
  end

  // NOTE: the per-button counters sit in a register array but are still reset; they are a handful of flops, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (press_cond[i])                         count[i] <= 8'(HOLD_TICKS);
        else if (repeat_cond[i])                   count[i] <= 8'(REPEAT_TICKS);
        else if (button_in[i] && state[i] != IDLE && tick) count[i] <= count[i] - 8'd1;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{32'(DIV_WIDTH), 32'(HOLD_TICKS), 32'(REPEAT_TICKS)};
  assign repeat_cond = '0;
`endif

  // NOTE: all state and output registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) state[i] <= IDLE;
      press_pulse   <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      held          <= '0;
      any_event     <= 1'b0;
    end else begin
      press_pulse   <= press_cond;
      release_pulse <= release_cond;
      repeat_pulse  <= repeat_cond;
      any_event     <= |{press_cond, release_cond, repeat_cond};
      for (int i = 0; i < 4; i++) begin
        held[i] <= press_cond[i] || ((state[i] != IDLE) && !release_cond[i]);
        if (press_cond[i])        state[i] <= HOLD;
        else if (release_cond[i]) state[i] <= IDLE;
        else if (repeat_cond[i])  state[i] <= REPEAT;
      end
    end
  end

endmodule
